yacht_game_ctrl: RTL

Parametrised successor of the two-player Yacht turn controller. It supports N players, a configurable category count and a configurable roll limit. It also tracks which categories each player has already used, so no player can score the same category twice. It sits between the debounced button inputs and the dice/score datapath, and at end of game it applies the upper-section bonus and resolves the winner.

---
 rtl/yacht_game_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/yacht_game_ctrl.sv
// Yacht turn controller for N players: roll/select/commit sequencing, per-player
// used-category tracking, saturating totals, end-of-game upper bonus and winner resolution.

module yacht_player_slot #(
  parameter int NUM_CATS     = 12,
  parameter int UPPER_CATS   = 6,
  parameter int BONUS_THRESH = 63,
  parameter int BONUS_PTS    = 35,
  parameter int SCORE_W      = 9,
  parameter int CW           = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                commit_en,
  input  logic                bonus_en,
  input  logic [CW-1:0]       cat_idx,
  input  logic [7:0]          calc_score,
  output logic [SCORE_W-1:0]  score,
  output logic [SCORE_W-1:0]  score_nxt,
  output logic [NUM_CATS-1:0] used
);
  localparam int AW = ((SCORE_W > 8) ? SCORE_W : 8) + 2;
  localparam logic [AW-1:0] SMAX = AW'((1 << SCORE_W) - 1);

  logic [9:0]    upper_sum;
  logic [10:0]   upper_add;
  logic [AW-1:0] add_val;
  logic [AW-1:0] sum;
  logic          is_upper;

  // score_nxt doubles as the post-bonus total the top uses to pick the winner
  always_comb begin
    is_upper  = int'(cat_idx) < UPPER_CATS;
    add_val   = '0;
    if (commit_en)
      add_val = AW'(calc_score);
    else if (bonus_en && int'(upper_sum) >= BONUS_THRESH)
      add_val = AW'(BONUS_PTS);
    sum       = AW'(score) + add_val;
    score_nxt = (sum > SMAX) ? SMAX[SCORE_W-1:0] : sum[SCORE_W-1:0];
    upper_add = {1'b0, upper_sum} + 11'(calc_score);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score     <= '0;
      upper_sum <= '0;
      used      <= '0;
    end else begin
      score <= score_nxt;
      if (commit_en) begin
        used[cat_idx] <= 1'b1;
        if (is_upper)
          upper_sum <= upper_add[10] ? 10'h3ff : upper_add[9:0];
      end
    end
  end
endmodule

module yacht_game_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_CATS     = 12,
  parameter int UPPER_CATS   = 6,
  parameter int MAX_ROLLS    = 3,
  parameter int BONUS_THRESH = 63,
  parameter int BONUS_PTS    = 35,
  parameter int SCORE_W      = 9,
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int CW = (NUM_CATS > 1) ? $clog2(NUM_CATS) : 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           btn_roll,
  input  logic                           btn_sel,
  input  logic                           btn_prev,
  input  logic                           btn_next,
  input  logic [7:0]                     calc_score,
  output logic [3:0]                     state_dbg,
  output logic [PW-1:0]                  player_idx,
  output logic                           roll_trigger,
  output logic [2:0]                     roll_cnt,
  output logic [CW-1:0]                  cat_idx,
  output logic [CW:0]                    round_num,
  output logic [NUM_CATS-1:0]            used_mask,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           game_over,
  output logic [PW-1:0]                  winner_idx,
  output logic                           tie
);
  localparam logic [3:0] S_INIT       = 4'd0;
  localparam logic [3:0] S_TURN_START = 4'd1;
  localparam logic [3:0] S_WAIT       = 4'd2;
  localparam logic [3:0] S_ROLL       = 4'd3;
  localparam logic [3:0] S_SELECT     = 4'd4;
  localparam logic [3:0] S_COMMIT     = 4'd5;
  localparam logic [3:0] S_NEXT       = 4'd6;
  localparam logic [3:0] S_BONUS      = 4'd7;
  localparam logic [3:0] S_END        = 4'd8;
  localparam int STAGES = 2;
  localparam logic [CW:0] RND_ONE = {{CW{1'b0}}, 1'b1};

  logic [3:0] state, state_nxt;
  logic [STAGES-1:0] vld_pipe;
  logic act_roll, act_sel, act_next, act_prev, roll_ok, last_turn;
  logic [NUM_PLAYERS-1:0] commit_en;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]  score_q, score_nxt;
  logic [NUM_PLAYERS-1:0][NUM_CATS-1:0] used_all;
  logic [CW-1:0] first_free, nxt_free, prv_free;
  logic found_f, found_n, found_p;
  int jn, jp;
  logic [SCORE_W-1:0] best;
  logic [PW-1:0] win_c;
  logic [3:0] n_best;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_slot
    yacht_player_slot #(
      .NUM_CATS(NUM_CATS), .UPPER_CATS(UPPER_CATS), .BONUS_THRESH(BONUS_THRESH),
      .BONUS_PTS(BONUS_PTS), .SCORE_W(SCORE_W), .CW(CW)
    ) u_slot (
      .clk(clk), .reset_n(reset_n), .commit_en(commit_en[p]),
      .bonus_en(state == S_BONUS), .cat_idx(cat_idx), .calc_score(calc_score),
      .score(score_q[p]), .score_nxt(score_nxt[p]), .used(used_all[p])
    );
  end

  assign scores       = score_q;
  assign used_mask    = used_all[player_idx];
  assign state_dbg    = state;
  assign game_over    = (state == S_END);
  assign roll_trigger = vld_pipe[STAGES-1];

  // one button per cycle: roll > sel > next > prev
  always_comb begin
    act_roll  = btn_roll;
    act_sel   = !btn_roll && btn_sel;
    act_next  = !btn_roll && !btn_sel && btn_next;
    act_prev  = !btn_roll && !btn_sel && !btn_next && btn_prev;
    roll_ok   = int'(roll_cnt) < MAX_ROLLS;
    last_turn = (int'(player_idx) >= NUM_PLAYERS - 1) && (int'(round_num) >= NUM_CATS);
    for (int p = 0; p < NUM_PLAYERS; p++)
      commit_en[p] = (state == S_COMMIT) && (player_idx == PW'(p));
  end

  // free-category search over the active player's mask, wrapping both ways
  always_comb begin
    first_free = '0;
    found_f    = 1'b0;
    nxt_free   = cat_idx;
    prv_free   = cat_idx;
    found_n    = 1'b0;
    found_p    = 1'b0;
    jn         = 0;
    jp         = 0;
    for (int c = 0; c < NUM_CATS; c++)
      if (!found_f && !used_mask[CW'(c)]) begin
        first_free = CW'(c);
        found_f    = 1'b1;
      end
    for (int k = 1; k < NUM_CATS; k++) begin
      jn = int'(cat_idx) + k;
      if (jn >= NUM_CATS) jn = jn - NUM_CATS;
      jp = int'(cat_idx) - k;
      if (jp < 0) jp = jp + NUM_CATS;
      if (!found_n && !used_mask[CW'(jn)]) begin
        nxt_free = CW'(jn);
        found_n  = 1'b1;
      end
      if (!found_p && !used_mask[CW'(jp)]) begin
        prv_free = CW'(jp);
        found_p  = 1'b1;
      end
    end
  end

  // winner is judged on the totals that will be latched when leaving S_BONUS
  always_comb begin
    best   = score_nxt[0];
    win_c  = '0;
    n_best = '0;
    for (int p = 1; p < NUM_PLAYERS; p++)
      if (score_nxt[PW'(p)] > best) begin
        best  = score_nxt[PW'(p)];
        win_c = PW'(p);
      end
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (score_nxt[PW'(p)] == best) n_best = n_best + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:       state_nxt = S_TURN_START;
      S_TURN_START: state_nxt = S_WAIT;
      S_WAIT:
        if (act_roll && roll_ok)             state_nxt = S_ROLL;
        else if (act_sel && roll_cnt != '0)  state_nxt = S_SELECT;
      S_ROLL:       state_nxt = (int'(roll_cnt) + 1 >= MAX_ROLLS) ? S_SELECT : S_WAIT;
      S_SELECT:
        if (act_roll && roll_ok)             state_nxt = S_ROLL;
        else if (act_sel)                    state_nxt = S_COMMIT;
      S_COMMIT:     state_nxt = S_NEXT;
      S_NEXT:       state_nxt = last_turn ? S_BONUS : S_TURN_START;
      S_BONUS:      state_nxt = S_END;
      S_END:        state_nxt = S_END;
      default:      state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_INIT;
      vld_pipe   <= '0;
      player_idx <= '0;
      roll_cnt   <= '0;
      cat_idx    <= '0;
      round_num  <= RND_ONE;
      winner_idx <= '0;
      tie        <= 1'b0;
    end else begin
      state    <= state_nxt;
      vld_pipe <= {vld_pipe[STAGES-2:0], state_nxt == S_ROLL};
      case (state)
        S_TURN_START: begin
          roll_cnt <= '0;
          cat_idx  <= first_free;
        end
        S_ROLL: roll_cnt <= roll_cnt + 3'd1;
        S_SELECT:
          if (act_next)      cat_idx <= nxt_free;
          else if (act_prev) cat_idx <= prv_free;
        S_NEXT:
          if (int'(player_idx) < NUM_PLAYERS - 1) begin
            player_idx <= player_idx + 1'b1;
          end else if (int'(round_num) < NUM_CATS) begin
            player_idx <= '0;
            round_num  <= round_num + 1'b1;
          end
        S_BONUS: begin
          winner_idx <= win_c;
          tie        <= (n_best > 4'd1);
        end
        default: ;
      endcase
    end
  end
endmodule
